// File: rtl/uart_mat_pkg.sv
// Shared types and constants for the matrix UART return path.
// Byte order here must match the receive-side H/Y assembler.
package uart_mat_pkg;

    localparam int unsigned BYTES_PER_ELEM = 8;
    localparam int unsigned DEFAULT_ROWS   = 4;
    localparam int unsigned DEFAULT_COLS   = 2;

    // Each 32-bit part goes out most significant byte first, real part before imaginary.
    localparam bit BYTE_ORDER_MSB_FIRST = 1'b1;

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StSend,
        StCsum,
        StCsumSend,
        StFinish
    } tx_state_e;

    typedef enum logic [1:0] {
        HsIdle,
        HsStrobe,
        HsWaitHi,
        HsWaitLo
    } hs_state_e;

    function automatic logic [7:0] elem_byte(input logic [31:0] re, input logic [31:0] im,
                                             input logic [2:0] idx);
        logic [31:0] word;
        logic [1:0]  lane;
        word = idx[2] ? im : re;
        lane = BYTE_ORDER_MSB_FIRST ? (2'd3 - idx[1:0]) : idx[1:0];
        return word[{lane, 3'b000} +: 8];
    endfunction

endpackage

// File: rtl/tx_byte_handshake.sv
// One-byte strobe/busy handshake against async_transmitter's TxD_busy.
// Pulses byte_accepted in the cycle TxD_busy is seen low again after the strobe.
module tx_byte_handshake
    import uart_mat_pkg::*;
(
    input  logic CLOCK_50,
    input  logic reset_n,
    input  logic go,
    input  logic tx_busy,
    output logic tx_start,
    output logic byte_accepted
);

    hs_state_e state_q, state_d;

    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= HsIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        tx_start      = 1'b0;
        byte_accepted = 1'b0;
        unique case (state_q)
            HsIdle: begin
                if (go) begin
                    state_d = HsStrobe;
                end
            end
            HsStrobe: begin
                tx_start = 1'b1;
                state_d  = HsWaitHi;
            end
            HsWaitHi: begin
                if (tx_busy) begin
                    state_d = HsWaitLo;
                end
            end
            HsWaitLo: begin
                if (!tx_busy) begin
                    byte_accepted = 1'b1;
                    state_d       = HsIdle;
                end
            end
            default: state_d = HsIdle;
        endcase
    end

endmodule

// File: rtl/matrix_uart_sender.sv
// Streams a ROWS x COLS complex matrix to async_transmitter, row-major, MSB first.
// Define MATRIX_TX_CHECKSUM_EN to append an XOR checksum byte after the data.
module matrix_uart_sender
    import uart_mat_pkg::*;
#(
    parameter int unsigned ROWS   = DEFAULT_ROWS,
    parameter int unsigned COLS   = DEFAULT_COLS,
    parameter int unsigned WORD_W = 32,
    localparam int unsigned ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1,
    localparam int unsigned COL_W = (COLS > 1) ? $clog2(COLS) : 1
) (
    input  logic              CLOCK_50,
    input  logic              reset_n,
    input  logic              wr_en,
    input  logic [ROW_W-1:0]  wr_row,
    input  logic [COL_W-1:0]  wr_col,
    input  logic [WORD_W-1:0] wr_re,
    input  logic [WORD_W-1:0] wr_im,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              tx_start,
    output logic [7:0]        tx_data,
    input  logic              tx_busy
);

    localparam int unsigned NUM_ELEM = ROWS * COLS;
    localparam int unsigned ELEM_W   = (NUM_ELEM > 1) ? $clog2(NUM_ELEM) : 1;
    localparam logic [ELEM_W-1:0] LAST_ELEM = ELEM_W'(NUM_ELEM - 1);
    localparam logic [2:0]        LAST_BYTE = 3'(BYTES_PER_ELEM - 1);
`ifdef MATRIX_TX_CHECKSUM_EN
    localparam tx_state_e AFTER_DATA = StCsum;
`else
    localparam tx_state_e AFTER_DATA = StFinish;
`endif

    tx_state_e          state_q, state_d;
    logic [WORD_W-1:0]  re_q [NUM_ELEM];
    logic [WORD_W-1:0]  im_q [NUM_ELEM];
    logic [ELEM_W-1:0]  elem_q, elem_d;
    logic [2:0]         byte_q, byte_d;
    logic [7:0]         tx_data_q, tx_data_d;
    logic               hs_go;
    logic               byte_accepted;
    logic               wr_hit;
    logic [ELEM_W-1:0]  wr_idx;
`ifdef MATRIX_TX_CHECKSUM_EN
    logic [7:0]         csum_q, csum_d;
`endif

    // Writes are frozen while a frame is being serialised so the frame stays coherent.
    assign wr_hit = wr_en && !busy && (32'(wr_row) < ROWS) && (32'(wr_col) < COLS);
    assign wr_idx = ELEM_W'(32'(wr_row) * COLS + 32'(wr_col));

    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            re_q <= '{default: '0};
            im_q <= '{default: '0};
        end else if (wr_hit) begin
            re_q[wr_idx] <= wr_re;
            im_q[wr_idx] <= wr_im;
        end
    end

    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= StIdle;
            elem_q    <= '0;
            byte_q    <= '0;
            tx_data_q <= '0;
`ifdef MATRIX_TX_CHECKSUM_EN
            csum_q    <= '0;
`endif
        end else begin
            state_q   <= state_d;
            elem_q    <= elem_d;
            byte_q    <= byte_d;
            tx_data_q <= tx_data_d;
`ifdef MATRIX_TX_CHECKSUM_EN
            csum_q    <= csum_d;
`endif
        end
    end

    always_comb begin
        state_d   = state_q;
        elem_d    = elem_q;
        byte_d    = byte_q;
        tx_data_d = tx_data_q;
        hs_go     = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
`ifdef MATRIX_TX_CHECKSUM_EN
        csum_d    = csum_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StLoad;
                    elem_d  = '0;
                    byte_d  = '0;
`ifdef MATRIX_TX_CHECKSUM_EN
                    csum_d  = '0;
`endif
                end
            end
            StLoad: begin
                busy      = 1'b1;
                tx_data_d = elem_byte(re_q[elem_q], im_q[elem_q], byte_q);
                if (!tx_busy) begin
                    hs_go   = 1'b1;
                    state_d = StSend;
                end
            end
            StSend: begin
                busy = 1'b1;
                if (byte_accepted) begin
                    byte_d  = byte_q + 3'd1;
                    state_d = StLoad;
`ifdef MATRIX_TX_CHECKSUM_EN
                    csum_d  = csum_q ^ tx_data_q;
`endif
                    if (byte_q == LAST_BYTE) begin
                        elem_d = elem_q + ELEM_W'(1);
                        if (elem_q == LAST_ELEM) begin
                            state_d = AFTER_DATA;
                        end
                    end
                end
            end
`ifdef MATRIX_TX_CHECKSUM_EN
            StCsum: begin
                busy      = 1'b1;
                tx_data_d = csum_q;
                if (!tx_busy) begin
                    hs_go   = 1'b1;
                    state_d = StCsumSend;
                end
            end
            StCsumSend: begin
                busy = 1'b1;
                if (byte_accepted) begin
                    state_d = StFinish;
                end
            end
`endif
            StFinish: begin
                done    = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    assign tx_data = tx_data_q;

    tx_byte_handshake u_handshake (
        .CLOCK_50      (CLOCK_50),
        .reset_n       (reset_n),
        .go            (hs_go),
        .tx_busy       (tx_busy),
        .tx_start      (tx_start),
        .byte_accepted (byte_accepted)
    );

endmodule

// File: tb/tb_matrix_uart_sender.sv
// Self-checking bench for matrix_uart_sender with a behavioural async_transmitter.
module tb_matrix_uart_sender;

`ifdef MATRIX_TX_CHECKSUM_EN
    localparam int FRAME_LEN = 65;
`else
    localparam int FRAME_LEN = 64;
`endif

    logic        CLOCK_50 = 1'b0;
    logic        reset_n  = 1'b0;
    logic        wr_en    = 1'b0;
    logic [1:0]  wr_row   = '0;
    logic [0:0]  wr_col   = '0;
    logic [31:0] wr_re    = '0;
    logic [31:0] wr_im    = '0;
    logic        start    = 1'b0;
    logic        tx_busy  = 1'b0;
    logic        busy, done, tx_start;
    logic [7:0]  tx_data;

    int checks = 0;
    int errors = 0;

    logic [31:0] m_re [8];
    logic [31:0] m_im [8];
    logic [7:0]  exp_q [$];
    logic [7:0]  rx_q  [$];
    int          frame_bytes = 0;
    int          done_cnt    = 0;
    int          busy_len    = 3;
    int          busy_cnt    = 0;
    int          low_cnt     = 100;
    logic        prev_start  = 1'b0;

    typedef struct {
        int          row;
        int          col;
        logic [31:0] re;
        logic [31:0] im;
        int          frame_pos;
    } vec_t;
    vec_t vecs [8];

    always #10 CLOCK_50 = ~CLOCK_50;

    matrix_uart_sender #(
        .ROWS   (4),
        .COLS   (2),
        .WORD_W (32)
    ) dut (
        .CLOCK_50 (CLOCK_50),
        .reset_n  (reset_n),
        .wr_en    (wr_en),
        .wr_row   (wr_row),
        .wr_col   (wr_col),
        .wr_re    (wr_re),
        .wr_im    (wr_im),
        .start    (start),
        .busy     (busy),
        .done     (done),
        .tx_start (tx_start),
        .tx_data  (tx_data),
        .tx_busy  (tx_busy)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    // Transmitter model and scoreboard consumer; busy is not reset, like the real UART.
    always @(negedge CLOCK_50) begin
        if (tx_busy) low_cnt = 0;
        else         low_cnt++;
        if (tx_start) begin
            check("tx_start_width", 32'(prev_start), 32'd0);
            check("tx_start_overlap", 32'(tx_busy), 32'd0);
            check("byte_gap_ge2", 32'(low_cnt >= 2), 32'd1);
            rx_q.push_back(tx_data);
            frame_bytes++;
            if (exp_q.size() == 0) check("unexpected_byte", 32'(frame_bytes), 32'd0);
            else                   check("byte", 32'(tx_data), 32'(exp_q.pop_front()));
            tx_busy  = 1'b1;
            busy_cnt = busy_len;
        end else if (busy_cnt > 0) begin
            busy_cnt--;
            if (busy_cnt == 0) tx_busy = 1'b0;
        end
        prev_start = tx_start;
        if (done) begin
            done_cnt++;
            check("done_busy_low", 32'(busy), 32'd0);
        end
    end

    task automatic push_expected();
        logic [7:0] b;
`ifdef MATRIX_TX_CHECKSUM_EN
        logic [7:0] x;
        x = '0;
`endif
        for (int e = 0; e < 8; e++) begin
            for (int k = 0; k < 8; k++) begin
                b = (k < 4) ? 8'(m_re[e] >> (8 * (3 - k))) : 8'(m_im[e] >> (8 * (7 - k)));
                exp_q.push_back(b);
`ifdef MATRIX_TX_CHECKSUM_EN
                x = x ^ b;
`endif
            end
        end
`ifdef MATRIX_TX_CHECKSUM_EN
        exp_q.push_back(x);
`endif
    endtask

    task automatic write_elem(input int r, input int c, input logic [31:0] re,
                              input logic [31:0] im);
        wr_en  = 1'b1;
        wr_row = 2'(r);
        wr_col = 1'(c);
        wr_re  = re;
        wr_im  = im;
        @(negedge CLOCK_50);
        wr_en = 1'b0;
        m_re[r * 2 + c] = re;
        m_im[r * 2 + c] = im;
    endtask

    task automatic begin_frame();
        exp_q.delete();
        rx_q.delete();
        frame_bytes = 0;
        done_cnt    = 0;
        push_expected();
        start = 1'b1;
        @(negedge CLOCK_50);
        start = 1'b0;
    endtask

    task automatic finish_frame(input string tag);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 3000 && !seen; i++) begin
            @(negedge CLOCK_50);
            if (done) seen = 1'b1;
        end
        check({tag, "_done_in_budget"}, 32'(seen), 32'd1);
        repeat (3) @(negedge CLOCK_50);
        check({tag, "_frame_len"}, 32'(frame_bytes), 32'(FRAME_LEN));
        check({tag, "_done_once"}, 32'(done_cnt), 32'd1);
        check({tag, "_busy_after"}, 32'(busy), 32'd0);
        check({tag, "_sb_empty"}, 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] re, im;
        bit          hit;

        for (int i = 0; i < 8; i++) begin
            m_re[i] = '0;
            m_im[i] = '0;
        end
        vecs[0] = '{3, 1, 32'h1111_2222, 32'h3333_4444, 7};
        vecs[1] = '{0, 0, 32'hA1B2_C3D4, 32'hE5F6_0718, 0};
        vecs[2] = '{2, 0, 32'h0F0E_0D0C, 32'h0B0A_0908, 4};
        vecs[3] = '{0, 1, 32'hDEAD_BEEF, 32'hCAFE_F00D, 1};
        vecs[4] = '{1, 1, 32'h8000_0001, 32'h7FFF_FFFE, 3};
        vecs[5] = '{1, 0, 32'h1234_5678, 32'h9ABC_DEF0, 2};
        vecs[6] = '{3, 0, 32'hFFFF_FFFF, 32'h0000_0001, 6};
        vecs[7] = '{2, 1, 32'h5A5A_A5A5, 32'hC3C3_3C3C, 5};

        repeat (2) @(negedge CLOCK_50);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        check("reset_tx_start", 32'(tx_start), 32'd0);
        check("reset_tx_data", 32'(tx_data), 32'h00);
        reset_n = 1'b1;
        @(negedge CLOCK_50);

        // Single element, then the first-strobe latency.
        write_elem(0, 0, 32'h3F80_0000, 32'hBF80_0000);
        begin_frame();
        check("busy_after_start", 32'(busy), 32'd1);
        check("no_strobe_in_load", 32'(tx_start), 32'd0);
        @(negedge CLOCK_50);
        check("first_strobe", 32'(tx_start), 32'd1);
        check("first_byte", 32'(tx_data), 32'h3F);
        finish_frame("t1");
        check("t1_byte1", 32'(rx_q[1]), 32'h80);
        check("t1_byte4", 32'(rx_q[4]), 32'hBF);
        check("t1_byte63", 32'(rx_q[63]), 32'h00);

        // Full matrix from the table, reconstructed row-major.
        foreach (vecs[i]) write_elem(vecs[i].row, vecs[i].col, vecs[i].re, vecs[i].im);
        begin_frame();
        finish_frame("t2");
        foreach (vecs[i]) begin
            re = {rx_q[vecs[i].frame_pos * 8 + 0], rx_q[vecs[i].frame_pos * 8 + 1],
                  rx_q[vecs[i].frame_pos * 8 + 2], rx_q[vecs[i].frame_pos * 8 + 3]};
            im = {rx_q[vecs[i].frame_pos * 8 + 4], rx_q[vecs[i].frame_pos * 8 + 5],
                  rx_q[vecs[i].frame_pos * 8 + 6], rx_q[vecs[i].frame_pos * 8 + 7]};
            check("t2_recon_re", re, vecs[i].re);
            check("t2_recon_im", im, vecs[i].im);
        end

        // Write and restart attempts mid-frame must be ignored.
        begin_frame();
        repeat (30) @(negedge CLOCK_50);
        check("t3_busy_mid", 32'(busy), 32'd1);
        wr_en  = 1'b1;
        wr_row = 2'd1;
        wr_col = 1'd1;
        wr_re  = 32'hDEAD_DEAD;
        wr_im  = 32'hBAD0_BAD0;
        start  = 1'b1;
        @(negedge CLOCK_50);
        wr_en = 1'b0;
        start = 1'b0;
        finish_frame("t3");

        // Slow transmitter: busy held 5 cycles longer.
        busy_len = 8;
        begin_frame();
        finish_frame("t4");
        busy_len = 3;

        // Reset part-way through a frame.
        begin_frame();
        hit = 1'b0;
        for (int i = 0; i < 3000 && !hit; i++) begin
            @(negedge CLOCK_50);
            if (frame_bytes >= 20) hit = 1'b1;
        end
        check("t5_reached_byte20", 32'(hit), 32'd1);
        reset_n = 1'b0;
        #1;
        check("t5_rst_busy", 32'(busy), 32'd0);
        check("t5_rst_tx_start", 32'(tx_start), 32'd0);
        check("t5_rst_tx_data", 32'(tx_data), 32'h00);
        check("t5_rst_done", 32'(done), 32'd0);
        exp_q.delete();
        for (int i = 0; i < 8; i++) begin
            m_re[i] = '0;
            m_im[i] = '0;
        end
        @(negedge CLOCK_50);
        reset_n = 1'b1;
        @(negedge CLOCK_50);
        begin_frame();
        finish_frame("t5");
        check("t5_zero_byte0", 32'(rx_q[0]), 32'h00);

        // Checksum byte (or its absence).
        write_elem(0, 0, 32'h0102_0304, 32'h0000_0000);
        begin_frame();
        finish_frame("t6");
        check("t6_byte3", 32'(rx_q[3]), 32'h04);
`ifdef MATRIX_TX_CHECKSUM_EN
        check("t6_csum", 32'(rx_q[64]), 32'h04);
`else
        check("t6_no_csum", 32'(rx_q.size()), 32'd64);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
